mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/alu_pkg.sv | 18 +
 rtl/mult_arbiter_rr_pick2.sv | 25 ++
 rtl/mult_arbiter.sv | 131 +++++++++++++
 tb/tb_mult_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the multiplier arbiter and its helpers.
package alu_pkg;

  localparam int OP_W        = 16;  // operand width of the shared multiplier
  localparam int RES_W       = 32;  // product width
  localparam int ST_W        = 3;   // width of the encoded FSM state
  localparam int TIMEOUT_DEF = 24;  // default WAIT-state cycle limit

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/mult_arbiter_rr_pick2.sv
// Two-way round-robin picker: with both requests high, the requester that
// was not served last wins; a lone request always wins.
module rr_pick2
  import alu_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last,   // 1 = requester 1 was served last
  output logic [1:0] grant   // one-hot, bit N = requester N
);

  // Pure combinational pick.
  always_comb begin
    // NOTE: default assignment first so every path assigns grant; no latch.
    grant = 2'b00;
    if (req0 && req1) begin
      grant = last ? 2'b01 : 2'b10;
    end else if (req0) begin
      grant = 2'b01;
    end else if (req1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Arbitrates two requesters onto one shared sequential 16x16 multiplier.
// Each transaction walks IDLE -> LOAD -> START -> WAIT -> RESP/ERR -> IDLE.
// All outputs except busy/state_out are registered.
module mult_arbiter
  import alu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset_a,
  input  logic              req0,
  input  logic              req1,
  input  logic [OP_W-1:0]   opa0,
  input  logic [OP_W-1:0]   opb0,
  input  logic [OP_W-1:0]   opa1,
  input  logic [OP_W-1:0]   opb1,
  output logic              grant0,
  output logic              grant1,
  output logic              rsp_valid0,
  output logic              rsp_valid1,
  output logic [RES_W-1:0]  result,
  output logic              rsp_err,
  output logic              mult_start,
  output logic [OP_W-1:0]   mult_dataa,
  output logic [OP_W-1:0]   mult_datab,
  input  logic              mult_done,
  input  logic [RES_W-1:0]  mult_product,
  output logic              busy,
  output logic [ST_W-1:0]   state_out
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  // The counter starts at 0 in the first WAIT cycle, so TIMEOUT-1 marks
  // the last permitted WAIT cycle.
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state;
  logic              owner;     // 0 = requester 0, 1 = requester 1
  logic              last;      // round-robin pointer: who was served last
  logic [CNT_W-1:0]  wait_cnt;
  logic [1:0]        pick;

  rr_pick2 u_pick (
    .req0  (req0),
    .req1  (req1),
    .last  (last),
    .grant (pick)
  );

  assign busy      = (state != ST_IDLE);
  assign state_out = state;

  // Transaction FSM with registered outputs, wait counter and RR pointer.
  always_ff @(posedge clk) begin
    // NOTE: synchronous reset clears every register, including the data
    // path, so a mid-transaction reset leaves no stale product or pulse.
    if (reset_a) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last       <= 1'b1;  // favour requester 0 after reset
      wait_cnt   <= '0;
      grant0     <= 1'b0;
      grant1     <= 1'b0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      result     <= '0;
      rsp_err    <= 1'b0;
      mult_start <= 1'b0;
      mult_dataa <= '0;
      mult_datab <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; the defaults below are
      // overridden by later assignments in the same cycle.
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      mult_start <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (pick != 2'b00) begin
            owner  <= pick[1];
            last   <= pick[1];
            grant0 <= pick[0];
            grant1 <= pick[1];
            state  <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          mult_dataa <= owner ? opa1 : opa0;
          mult_datab <= owner ? opb1 : opb0;
          mult_start <= 1'b1;  // high during the START cycle only
          state      <= ST_START;
        end

        ST_START: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end

        ST_WAIT: begin
          if (mult_done) begin
            // A done on the final WAIT cycle still counts as success.
            result     <= mult_product;
            rsp_err    <= 1'b0;
            rsp_valid0 <= ~owner;
            rsp_valid1 <= owner;
            state      <= ST_RESP;
          end else if (wait_cnt == CNT_LAST) begin
            result     <= '0;
            rsp_err    <= 1'b1;
            rsp_valid0 <= ~owner;
            rsp_valid1 <= owner;
            state      <= ST_ERR;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        ST_RESP, ST_ERR: begin
          grant0 <= 1'b0;
          grant1 <= 1'b0;
          state  <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter. The bench plays the multiplier: it
// drives mult_done / mult_product with hand-computed products.
module tb_mult_arbiter;

  logic        clk = 1'b0;
  logic        reset_a;
  logic        req0, req1;
  logic [15:0] opa0, opb0, opa1, opb1;
  logic        grant0, grant1;
  logic        rsp_valid0, rsp_valid1;
  logic [31:0] result;
  logic        rsp_err;
  logic        mult_start;
  logic [15:0] mult_dataa, mult_datab;
  logic        mult_done;
  logic [31:0] mult_product;
  logic        busy;
  logic [2:0]  state_out;

  int n_checks = 0;
  int n_errors = 0;

  mult_arbiter #(.TIMEOUT(24)) dut (
    .clk          (clk),
    .reset_a      (reset_a),
    .req0         (req0),
    .req1         (req1),
    .opa0         (opa0),
    .opb0         (opb0),
    .opa1         (opa1),
    .opb1         (opb1),
    .grant0       (grant0),
    .grant1       (grant1),
    .rsp_valid0   (rsp_valid0),
    .rsp_valid1   (rsp_valid1),
    .result       (result),
    .rsp_err      (rsp_err),
    .mult_start   (mult_start),
    .mult_dataa   (mult_dataa),
    .mult_datab   (mult_datab),
    .mult_done    (mult_done),
    .mult_product (mult_product),
    .busy         (busy),
    .state_out    (state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; everything is sampled and driven 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_a = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    opa0 = '0; opb0 = '0; opa1 = '0; opb1 = '0;
    mult_done = 1'b0; mult_product = '0;
    repeat (2) step();

    // ---- reset state
    check("rst_state", state_out, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", {grant1, grant0}, 0);
    check("rst_start", mult_start, 0);
    check("rst_data", {mult_dataa, mult_datab}, 0);
    check("rst_result", result, 0);
    check("rst_rsp", {rsp_valid1, rsp_valid0, rsp_err}, 0);
    reset_a = 1'b0;

    // ---- basic op on requester 0: 0x1234 * 0x0010
    req0 = 1'b1; opa0 = 16'h1234; opb0 = 16'h0010;
    step();
    check("t1_load_state", state_out, 1);
    check("t1_load_grant", {grant1, grant0}, 2'b01);
    check("t1_load_busy", busy, 1);
    step();
    check("t1_start_state", state_out, 2);
    check("t1_start_pulse", mult_start, 1);
    check("t1_dataa", mult_dataa, 16'h1234);
    check("t1_datab", mult_datab, 16'h0010);
    req0 = 1'b0;
    step();
    check("t1_wait_state", state_out, 3);
    check("t1_wait_start_low", mult_start, 0);
    mult_done = 1'b1; mult_product = 32'h0001_2340;
    step();
    check("t1_resp_state", state_out, 4);
    check("t1_rsp_valid", {rsp_valid1, rsp_valid0}, 2'b01);
    check("t1_result", result, 32'h0001_2340);
    check("t1_rsp_err", rsp_err, 0);
    check("t1_resp_grant", grant0, 1);
    mult_done = 1'b0; mult_product = '0;
    step();
    check("t1_idle_state", state_out, 0);
    check("t1_single_pulse", {rsp_valid1, rsp_valid0}, 0);
    check("t1_idle_grant", {grant1, grant0}, 0);

    // ---- simultaneous requests from reset, round-robin, req1 dropped in WAIT
    reset_a = 1'b1;
    step();
    reset_a = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    opa0 = 16'h0002; opb0 = 16'h0003; opa1 = 16'hFFFF; opb1 = 16'hFFFF;
    step();
    check("t2_first_grant", {grant1, grant0}, 2'b01);
    step();
    check("t2_first_dataa", mult_dataa, 16'h0002);
    step();
    mult_done = 1'b1; mult_product = 32'h0000_0006;
    step();
    check("t2_first_rsp", {rsp_valid1, rsp_valid0}, 2'b01);
    check("t2_first_result", result, 32'h0000_0006);
    req0 = 1'b0; mult_done = 1'b0;
    step();
    check("t2_gap_idle", state_out, 0);
    step();
    check("t2_second_grant", {grant1, grant0}, 2'b10);
    step();
    check("t2_second_dataa", mult_dataa, 16'hFFFF);
    check("t2_second_datab", mult_datab, 16'hFFFF);
    step();
    req1 = 1'b0;  // owner drops its request mid-WAIT
    step();
    step();
    check("t2_still_wait", state_out, 3);
    mult_done = 1'b1; mult_product = 32'hFFFE_0001;
    step();
    check("t2_second_rsp", {rsp_valid1, rsp_valid0}, 2'b10);
    check("t2_second_result", result, 32'hFFFE_0001);
    check("t2_second_err", rsp_err, 0);
    mult_done = 1'b0; mult_product = '0;
    step();

    // ---- timeout: mult_done withheld for 24 WAIT cycles
    req0 = 1'b1; opa0 = 16'h0007; opb0 = 16'h0009;
    step();
    step();
    req0 = 1'b0;
    step();  // first WAIT cycle
    for (int i = 2; i <= 24; i++) begin
      step();
      check($sformatf("t3_wait_%0d", i), {mult_start, state_out}, 4'h3);
    end
    step();
    check("t3_err_state", state_out, 5);
    check("t3_err_rsp", {rsp_valid1, rsp_valid0}, 2'b01);
    check("t3_err_flag", rsp_err, 1);
    check("t3_err_result", result, 0);
    step();
    check("t3_err_idle", {busy, rsp_valid0}, 0);

    // ---- next request completes normally
    req1 = 1'b1; opa1 = 16'h0003; opb1 = 16'h0005;
    step();
    check("t4_grant", {grant1, grant0}, 2'b10);
    step();
    check("t4_start", mult_start, 1);
    req1 = 1'b0;
    step();
    mult_done = 1'b1; mult_product = 32'h0000_000F;
    step();
    check("t4_rsp", {rsp_valid1, rsp_valid0, rsp_err}, 3'b100);
    check("t4_result", result, 32'h0000_000F);
    mult_done = 1'b0; mult_product = '0;
    step();

    // ---- reset during WAIT; a later mult_done is ignored
    req0 = 1'b1; opa0 = 16'h0100; opb0 = 16'h0100;
    step();
    step();
    req0 = 1'b0;
    step();
    check("t5_in_wait", state_out, 3);
    reset_a = 1'b1;
    step();
    check("t5_rst_state", state_out, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_rsp", {rsp_valid1, rsp_valid0}, 0);
    check("t5_rst_grant", {grant1, grant0}, 0);
    check("t5_rst_data", {mult_dataa, mult_datab}, 0);
    reset_a = 1'b0;
    mult_done = 1'b1; mult_product = 32'h0000_DEAD;
    step();
    check("t5_late_done_state", state_out, 0);
    check("t5_late_done_rsp", {rsp_valid1, rsp_valid0}, 0);
    step();
    check("t5_late_done_result", result, 0);
    mult_done = 1'b0; mult_product = '0;

    // ---- mult_done on the last WAIT cycle wins over timeout
    req1 = 1'b1; opa1 = 16'h00FF; opb1 = 16'h0101;
    step();
    check("t6_grant", {grant1, grant0}, 2'b10);
    step();
    req1 = 1'b0;
    step();  // first WAIT cycle
    repeat (23) step();
    check("t6_last_wait", state_out, 3);
    mult_done = 1'b1; mult_product = 32'h0000_FFFF;
    step();
    check("t6_resp_state", state_out, 4);
    check("t6_rsp", {rsp_valid1, rsp_valid0, rsp_err}, 3'b100);
    check("t6_result", result, 32'h0000_FFFF);
    mult_done = 1'b0; mult_product = '0;
    step();
    check("t6_idle", state_out, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
